// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high glyphs
// (bit 6 = segment a ... bit 0 = segment g), slot geometry and the
// prescaler divide helper.
package seg_pkg;

   localparam int SUBSLOTS   = 16;
   localparam int MAX_DIGITS = 8;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h7E;
   localparam seg_t SEG_1     = 7'h30;
   localparam seg_t SEG_2     = 7'h6D;
   localparam seg_t SEG_3     = 7'h79;
   localparam seg_t SEG_4     = 7'h33;
   localparam seg_t SEG_5     = 7'h5B;
   localparam seg_t SEG_6     = 7'h5F;
   localparam seg_t SEG_7     = 7'h70;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h7B;
   localparam seg_t SEG_A     = 7'h77;
   localparam seg_t SEG_B     = 7'h1F;  // lower-case b
   localparam seg_t SEG_C     = 7'h4E;
   localparam seg_t SEG_D     = 7'h3D;  // lower-case d
   localparam seg_t SEG_E     = 7'h4F;
   localparam seg_t SEG_F     = 7'h47;
   localparam seg_t SEG_BLANK = 7'h00;

   // Clocks per sub-slot tick; never below one so tiny clocks still scan.
   function automatic int calc_tick_div(input int clk_hz, input int refresh_hz,
                                        input int digits);
      int div;
      div = clk_hz / (digits * refresh_hz * SUBSLOTS);
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-high seven-segment glyph. The blank input forces
// every segment off; output polarity is handled by the caller.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   // Glyph lookup with blank override.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver for NUM_DIGITS common-anode digits.
// Each digit owns a slot of 16 sub-slot ticks; sub-slot 0 is always dark so
// the segment register can settle before the anode turns on, and sub-slots
// 1..brightness light the digit. Display data is double buffered: load
// writes the pending buffer, which moves to the shadow buffer at the end of
// every frame. Optional build macro: LEADING_ZERO_BLANK_EN blanks leading
// zero digits (digit 0 always shown) based on the shadow buffer.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int REFRESH_HZ  = 75,
   parameter int NUM_DIGITS  = 8,
   parameter bit ACTIVE_LOW  = 1'b1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] disp_data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   anode_sel,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic                    frame_done
);

   localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, REFRESH_HZ, NUM_DIGITS);
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [3:0]    SUB_LAST   = 4'(SUBSLOTS - 1);

   localparam logic [NUM_DIGITS-1:0] ANODE_POL = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};

   // ---------------------------------------------------------------------
   // Timing state
   // ---------------------------------------------------------------------
   logic [PW-1:0] presc_reg;
   logic [3:0]    sub_cnt_reg;
   logic [IW-1:0] idx_reg;

   logic tick;
   logic slot_end;
   logic frame_end;

   assign tick      = (presc_reg == PRESC_LAST);
   assign slot_end  = tick && (sub_cnt_reg == SUB_LAST);
   assign frame_end = slot_end && (idx_reg == IDX_LAST);

   // Prescaler, sub-slot counter and digit index advance together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_reg   <= '0;
         sub_cnt_reg <= '0;
         idx_reg     <= '0;
      end else begin
         if (tick) begin
            presc_reg   <= '0;
            sub_cnt_reg <= sub_cnt_reg + 4'd1;
         end else begin
            presc_reg <= presc_reg + PW'(1);
         end
         if (slot_end) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Double buffering
   // ---------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] pend_data_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg;
   logic [4*NUM_DIGITS-1:0] shad_data_reg;
   logic [NUM_DIGITS-1:0]   shad_dp_reg;

   // Pending captures every load; shadow swaps in at the frame boundary, and
   // a load coinciding with the boundary goes straight to the shadow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_data_reg <= '0;
         pend_dp_reg   <= '0;
         shad_data_reg <= '0;
         shad_dp_reg   <= '0;
      end else begin
         if (load) begin
            pend_data_reg <= disp_data;
            pend_dp_reg   <= dp_in;
         end
         if (frame_end) begin
            shad_data_reg <= load ? disp_data : pend_data_reg;
            shad_dp_reg   <= load ? dp_in     : pend_dp_reg;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Leading-zero blanking (derived from the shadow buffer only)
   // ---------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] blank_vec;

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] zero_vec;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
         assign zero_vec[gi] = (shad_data_reg[4*gi +: 4] == 4'h0);
      end
      // Digit gi is a leading zero when it and every higher digit are zero.
      assign blank_vec[0] = 1'b0;
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
         assign blank_vec[gi] = &zero_vec[NUM_DIGITS-1:gi];
      end
   endgenerate
`else
   assign blank_vec = '0;
`endif

   // ---------------------------------------------------------------------
   // Current-digit selection and decode
   // ---------------------------------------------------------------------
   logic [3:0] cur_nib;
   logic       cur_dp;
   logic       cur_blank;
   logic [6:0] seg_next;

   // Pick the shadow nibble, dp and blank flag of the digit being scanned.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_reg == IW'(i)) begin
            cur_nib   = shad_data_reg[4*i +: 4];
            cur_dp    = shad_dp_reg[i];
            cur_blank = blank_vec[i];
         end
      end
   end

   seg_hex_decode u_dec (
      .nibble (cur_nib),
      .blank  (cur_blank),
      .seg    (seg_next)
   );

   // ---------------------------------------------------------------------
   // Anode selection: lit only inside the brightness window of its slot
   // ---------------------------------------------------------------------
   logic                  lit_window;
   logic [NUM_DIGITS-1:0] anode_next;

   assign lit_window = (sub_cnt_reg != 4'd0) && (sub_cnt_reg <= brightness);

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
         assign anode_next[gi] = lit_window && digit_en[gi] && (idx_reg == IW'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Registered outputs with polarity applied
   // ---------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] anode_reg;
   logic [6:0]            seg_reg;
   logic                  dp_reg;
   logic                  frame_done_reg;

   // Anodes follow the counters every cycle; segments and dp only refresh in
   // the dark sub-slot 0 so they are settled before any anode lights.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         anode_reg      <= ANODE_POL;
         seg_reg        <= SEG_POL;
         dp_reg         <= ACTIVE_LOW;
         frame_done_reg <= 1'b0;
      end else begin
         anode_reg      <= anode_next ^ ANODE_POL;
         frame_done_reg <= frame_end;
         if (sub_cnt_reg == 4'd0) begin
            seg_reg <= seg_next ^ SEG_POL;
            dp_reg  <= cur_dp ^ ACTIVE_LOW;
         end
      end
   end

   assign anode_sel  = anode_reg;
   assign seg_out    = seg_reg;
   assign dp_out     = dp_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, TICK_DIV = 2, active-low).
// Stimulus pushes one expected-frame record at the frame_done that starts
// the frame to be judged; the monitor pops it on that frame_done and
// measures the following 128 cycles (glyph per lit digit, anode on-time per
// digit, dp on-time, one-hot anodes, frame period).
`timescale 1ns/1ps
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] disp_data = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic        load = 1'b0;
   logic [3:0]  brightness = '0;
   logic [3:0]  anode_sel;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic        frame_done;

   seg_scan_driver #(
      .CLK_FREQ_HZ (12800),
      .REFRESH_HZ  (100),
      .NUM_DIGITS  (4),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .disp_data  (disp_data),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .brightness (brightness),
      .anode_sel  (anode_sel),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Active-low glyphs, hand-derived from the a..g patterns.
   localparam logic [6:0] G0  = 7'b0000001;
   localparam logic [6:0] G1  = 7'b1001111;
   localparam logic [6:0] G2  = 7'b0010010;
   localparam logic [6:0] G3  = 7'b0000110;
   localparam logic [6:0] G4  = 7'b1001100;
   localparam logic [6:0] G6  = 7'b0100000;
   localparam logic [6:0] G8  = 7'b0000000;
   localparam logic [6:0] GA  = 7'b0001000;
   localparam logic [6:0] GB  = 7'b1100000;
   localparam logic [6:0] GC  = 7'b0110001;
   localparam logic [6:0] GD  = 7'b1000010;
   localparam logic [6:0] GE  = 7'b0110000;
   localparam logic [6:0] GF  = 7'b0111000;
   localparam logic [6:0] GBL = 7'b1111111;

   typedef struct packed {
      logic [27:0] segs;    // digit i glyph at [7i+6:7i]
      logic [3:0]  mask;    // digits whose glyph is checked
      logic [31:0] on_cnt;  // digit i lit cycles at [8i+7:8i]
      logic [7:0]  dp_cnt;  // cycles with dp lit
   } frame_exp_t;

   frame_exp_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   bit mon_busy = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic frame_exp_t mk(input logic [27:0] segs, input logic [3:0] mask,
                                     input logic [31:0] on, input logic [7:0] dpc);
      frame_exp_t r;
      r.segs   = segs;
      r.mask   = mask;
      r.on_cnt = on;
      r.dp_cnt = dpc;
      return r;
   endfunction

   // Returns in the first cycle (posedge + 1) that shows frame_done.
   task automatic wait_frame(input string tag);
      int k;
      for (k = 0; k < 400; k++) begin
         @(posedge clk);
         #1;
         if (frame_done) break;
      end
      if (k >= 400) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_%s: no frame_done within 400 clk, expected a pulse", tag);
      end
   endtask

   task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
      @(posedge clk);
      #1;
      disp_data = d;
      dp_in     = dp;
      load      = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Monitor: judges one frame per queued record.
   initial begin : monitor
      frame_exp_t rec;
      logic [6:0] cap [4];
      bit         got [4];
      bit         unst [4];
      int         on [4];
      int         dpc, multi, fd_early, actc, frame_no, sv;
      frame_no = 0;
      @(negedge clk);
      forever begin
         if (frame_done === 1'b1 && exp_q.size() != 0) begin
            mon_busy = 1'b1;
            rec = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
               cap[i] = '0; got[i] = 1'b0; unst[i] = 1'b0; on[i] = 0;
            end
            dpc = 0; multi = 0; fd_early = 0;
            for (int n = 1; n <= 128; n++) begin
               @(negedge clk);
               actc = 0;
               for (int i = 0; i < 4; i++) begin
                  if (anode_sel[i] == 1'b0) begin
                     on[i]++;
                     actc++;
                     if (!got[i]) begin
                        cap[i] = seg_out;
                        got[i] = 1'b1;
                     end else if (cap[i] != seg_out) begin
                        unst[i] = 1'b1;
                     end
                  end
               end
               if (actc > 1) multi++;
               if (dp_out == 1'b0) dpc++;
               if (n < 128 && frame_done) fd_early++;
            end
            for (int i = 0; i < 4; i++) begin
               if (rec.mask[i]) begin
                  sv = (got[i] && !unst[i]) ? int'(cap[i]) : -1;
                  check($sformatf("frame%0d_seg_d%0d", frame_no, i), sv, int'(rec.segs[7*i +: 7]));
               end
               check($sformatf("frame%0d_on_d%0d", frame_no, i), on[i], int'(rec.on_cnt[8*i +: 8]));
            end
            check($sformatf("frame%0d_dp_cycles", frame_no), dpc, int'(rec.dp_cnt));
            check($sformatf("frame%0d_onehot", frame_no), multi, 0);
            check($sformatf("frame%0d_fd_early", frame_no), fd_early, 0);
            check($sformatf("frame%0d_period", frame_no), int'(frame_done), 1);
            $display("frame %0d judged, errors so far %0d", frame_no, n_errors);
            frame_no++;
            mon_busy = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   end

   // Stimulus.
   initial begin : stimulus
      int k;
      // Reset held for three clocks.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_anode", int'(anode_sel), 'hF);
      check("rst_seg", int'(seg_out), 'h7F);
      check("rst_dp", int'(dp_out), 1);
      check("rst_frame_done", int'(frame_done), 0);
      $display("reset checked");
      rst_n = 1'b1;

      // 1A3F at full brightness.
      digit_en   = 4'hF;
      brightness = 4'd15;
      pulse_load(16'h1A3F, 4'b0000);
      wait_frame("1a3f");
      exp_q.push_back(mk({G1, GA, G3, GF}, 4'hF, 32'h1E1E1E1E, 8'd0));

      // Brightness 4: sub-slots 1..4 lit, 8 clk per digit.
      wait_frame("b4");
      brightness = 4'd4;
      exp_q.push_back(mk({G1, GA, G3, GF}, 4'hF, 32'h08080808, 8'd0));

      // Brightness 0: dark for the whole frame.
      wait_frame("b0");
      brightness = 4'd0;
      exp_q.push_back(mk(28'h0, 4'h0, 32'h00000000, 8'd0));

      // 1111 shown; later loads in the frame do not disturb it, last wins.
      pulse_load(16'h1111, 4'b0000);
      wait_frame("ones");
      brightness = 4'd15;
      exp_q.push_back(mk({G1, G1, G1, G1}, 4'hF, 32'h1E1E1E1E, 8'd0));
      repeat (40) @(posedge clk);
      pulse_load(16'h3333, 4'b0000);
      repeat (20) @(posedge clk);
      pulse_load(16'h2222, 4'b0000);
      wait_frame("twos");
      exp_q.push_back(mk({G2, G2, G2, G2}, 4'hF, 32'h1E1E1E1E, 8'd0));

      // Digit enable 0101 with dp on digit 0.
      pulse_load(16'h5678, 4'b0001);
      wait_frame("mask");
      digit_en = 4'b0101;
      exp_q.push_back(mk({GBL, G6, GBL, G8}, 4'b0101, 32'h001E001E, 8'd32));

      // Load landing exactly on the frame boundary goes straight to shadow.
      wait_frame("pre_sim");
      digit_en = 4'hF;
      repeat (127) @(posedge clk);
      #1;
      disp_data = 16'hBCDE;
      dp_in     = 4'b0000;
      load      = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      check("fd_at_boundary", int'(frame_done), 1);
      exp_q.push_back(mk({GB, GC, GD, GE}, 4'hF, 32'h1E1E1E1E, 8'd0));

      // Zero digits: blanked only when the optional blanking is built in.
      pulse_load(16'h0040, 4'b0000);
      wait_frame("z40");
`ifdef LEADING_ZERO_BLANK_EN
      exp_q.push_back(mk({GBL, GBL, G4, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`else
      exp_q.push_back(mk({G0, G0, G4, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`endif
      pulse_load(16'h0000, 4'b0000);
      wait_frame("z00");
`ifdef LEADING_ZERO_BLANK_EN
      exp_q.push_back(mk({GBL, GBL, GBL, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`else
      exp_q.push_back(mk({G0, G0, G0, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`endif

      // Mid-operation reset: pending is cleared too, so the next frame is zeros.
      pulse_load(16'h9999, 4'b1111);
      wait_frame("pre_rst");
      repeat (50) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_anode", int'(anode_sel), 'hF);
      check("midrst_seg", int'(seg_out), 'h7F);
      check("midrst_dp", int'(dp_out), 1);
      check("midrst_frame_done", int'(frame_done), 0);
      rst_n = 1'b1;
      for (k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (frame_done) break;
      end
      check("midrst_first_frame_clk", k, 128);
`ifdef LEADING_ZERO_BLANK_EN
      exp_q.push_back(mk({GBL, GBL, GBL, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`else
      exp_q.push_back(mk({G0, G0, G0, G0}, 4'hF, 32'h1E1E1E1E, 8'd0));
`endif
      $display("mid-operation reset checked");

      // Drain the scoreboard.
      for (k = 0; k < 1000; k++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !mon_busy) break;
      end
      check("scoreboard_drained", exp_q.size() + int'(mon_busy), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed seven-segment scan driver, successor to the fixed 8-digit display block. Drives NUM_DIGITS common-anode digits from a packed hex bus with per-digit decimal points and per-digit enable mask. Adds frame-synchronous double buffering, 16-level PWM brightness with an anti-ghost dead slot, and selectable output polarity. Sits between CPU-visible registers (ACC/MR/debug values) and board pins.

Parameters:
CLK_FREQ_HZ, 10_000_000, system clock frequency in Hz
REFRESH_HZ, 75, full-frame refresh rate in Hz
NUM_DIGITS, 8, digit count, legal range 1..8
ACTIVE_LOW, 1, 1 = anode/segment/dp outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
disp_data  in  4*NUM_DIGITS  hex nibbles; digit i = disp_data[4i+3:4i]; digit 0 = rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  per-digit enable, 0 = digit dark (slot time still consumed)
load  in  1  one-cycle strobe; captures disp_data/dp_in into pending buffer
brightness  in  4  PWM level 0..15; 0 = dark
anode_sel  out  NUM_DIGITS  digit select, one-hot (polarity per ACTIVE_LOW)
seg_out  out  7  segments {a,b,c,d,e,f,g}, seg_out[6] = a, seg_out[0] = g
dp_out  out  1  decimal point segment
frame_done  out  1  one-cycle pulse when last digit slot ends

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. All outputs inactive (all-ones when ACTIVE_LOW=1, all-zeros otherwise); frame_done=0; counters, digit index, pending and shadow buffers cleared to 0.
- Tick: prescaler counts 0..TICK_DIV-1, TICK_DIV = max(1, CLK_FREQ_HZ/(NUM_DIGITS*REFRESH_HZ*16)); one-cycle tick at terminal count.
- Slot: each digit slot = 16 ticks, sub-slot counter sub_cnt 0..15 advancing on tick. On tick with sub_cnt=15: sub_cnt->0, digit index advances; index NUM_DIGITS-1 wraps to 0.
- Scan order: digit 0, 1, ..., NUM_DIGITS-1, repeat.
- Anode: digit idx active iff digit_en[idx]=1 AND 1 <= sub_cnt <= brightness. sub_cnt=0 always dark (anti-ghost). brightness=0 -> all dark; 15 -> 15/16 duty.
- Segment/dp outputs registered; updated only while sub_cnt=0 so they are stable before anode turns on. Decode from shadow nibble of current idx; standard hex glyphs 0-9, A, b, C, d, E, F (upper/lower case as listed).
- All outputs registered; anode/seg change one clk after the counter state selecting them.
- Buffering: load -> pending <= {disp_data, dp_in}. At frame boundary (tick with sub_cnt=15 and idx=NUM_DIGITS-1) shadow <= pending; frame_done pulses on that same cycle (registered, visible next clk).
- Simultaneous load and frame boundary: shadow takes the new disp_data/dp_in directly; pending also updated.
- Multiple loads within a frame: last one wins.
- Mid-operation reset: everything returns to reset state on the next clk edge; scan restarts at digit 0, sub_cnt 0.
- digit_en, brightness sampled live (not buffered).

Optional Feature:
LEADING_ZERO_BLANK_EN — when defined, any shadow digit that is 0 and has all higher-index shadow digits 0 is blanked (segments off, dp follows dp_in); digit 0 is never blanked, so value 0 shows a single "0". Blanking is computed from the shadow buffer, so it changes only at frame boundaries. When undefined, all zero digits display "0".

Decomposition:
- Shared package seg_pkg: 7-bit glyph constants SEG_0..SEG_F, SEG_BLANK, SUBSLOTS=16, MAX_DIGITS=8.
- One sub-module: seg_hex_decode (4-bit nibble + blank -> 7-bit active-high segments); polarity inversion applied in seg_scan_driver.

Test Plan:
- Sim params CLK_FREQ_HZ=12800, REFRESH_HZ=100, NUM_DIGITS=4 (TICK_DIV=2). Hold rst_n=0 for 3 clk -> anode_sel=4'hF, seg_out=7'h7F, dp_out=1, frame_done=0.
- load disp_data=16'h1A3F, digit_en=4'hF, brightness=15 -> after next frame_done, digit slots 0..3 show 7'b0111000 (F), 7'b0000110 (3), 7'b0001000 (A), 7'b1001111 (1); each anode low for 15 of 16 sub-slots.
- brightness=4 -> anode active exactly sub-slots 1..4 per slot (8 clk); brightness=0 -> anode_sel stays 4'hF for a full frame.
- load 16'h1111, then load 16'h2222 mid-frame -> current frame keeps shadow value, next frame shows all "2"; frame_done pulses every 128 clk.
- digit_en=4'b0101, dp_in=4'b0001 -> anodes 1 and 3 never active; dp_out=0 only during digit 0 slot.
- With LEADING_ZERO_BLANK_EN, load 16'h0040 -> digits 3,2 blank, digit 1 "4", digit 0 "0"; load 16'h0000 -> only digit 0 shows "0".
